// File: rtl/alu_rf_seq_ctrl.sv
// alu_rf_seq_ctrl: IDLE/DECODE/EXEC/WB sequencer for the ALU / register-file / immediate datapath.
// Define ALU_SEQ_PERF_CNT_EN to add the perf_retired retired-instruction counter.
module alu_rf_seq_ctrl #(
  parameter int INSTR_W     = 16,
  parameter int ADDR_W      = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  rf_raddr1,
  output logic [ADDR_W-1:0]  rf_raddr2,
  output logic [ADDR_W-1:0]  rf_waddr,
  output logic               rf_we,
  output logic [2:0]         imm_field,
  output logic [2:0]         alu_op,
  output logic               alu_src_imm,
  output logic               busy,
  output logic               done,
`ifdef ALU_SEQ_PERF_CNT_EN
  output logic               zero_flag,
  output logic [15:0]        perf_retired
`else
  output logic               zero_flag
`endif
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q;
  logic               xfer, exec_last, wb_we;
  always_comb begin
    xfer      = (state_q == IDLE) && instr_valid;
    exec_last = (state_q == EXEC) && (cnt_q == 4'd0);
    state_d   = IDLE;
    case (state_q)
      IDLE:    state_d = xfer ? DECODE : IDLE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = exec_last ? WB : EXEC;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == DECODE) ? 4'(EXEC_CYCLES - 1) :
            (state_q == EXEC)   ? cnt_q - 4'd1 : cnt_q;
    // register 0 is hardwired, and NOPs retire without writing
    wb_we = (state_d == WB) && (instr_q[15:13] != 3'b111) && (instr_q[12:10] != 3'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      rf_we       <= 1'b0;
      rf_raddr1   <= '0;
      rf_raddr2   <= '0;
      rf_waddr    <= '0;
      imm_field   <= '0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      zero_flag   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_ready <= state_d == IDLE;
      busy        <= state_d != IDLE;
      done        <= state_d == WB;
      rf_we       <= wb_we;
      if (xfer) instr_q <= instr;
      if (state_q == DECODE) begin
        alu_op      <= instr_q[15:13];
        rf_waddr    <= instr_q[12:10];
        rf_raddr1   <= instr_q[9:7];
        rf_raddr2   <= instr_q[6:4];
        imm_field   <= instr_q[3:1];
        alu_src_imm <= instr_q[0];
      end
      if (exec_last) zero_flag <= alu_zero;
    end
  end
`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) perf_retired <= '0;
    else if (state_q == WB) perf_retired <= perf_retired + 16'd1;
  end
`endif
endmodule

// File: tb/tb_alu_rf_seq_ctrl.sv
// tb_alu_rf_seq_ctrl: directed vector table plus multi-cycle corner sequences on three EXEC_CYCLES builds.
module tb_alu_rf_seq_ctrl;
  localparam int EC[3] = '{1, 3, 4};
  logic clk = 0, rst = 1, alu_zero = 0;
  logic [2:0] valid = '0;
  logic [15:0] instr = '0;
  logic rdy[3], busy[3], we[3], done[3], zf[3], src[3];
  logic [2:0] ra1[3], ra2[3], wa[3], imm[3], op[3];
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] perf[3];
`endif
  int pass = 0, total = 0, cyc = 0, wbc, d1, d2, dc0;
  int we_cnt[3], done_cnt[3];
  int acc[$];
  logic bprev = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_rf_seq_ctrl #(.EXEC_CYCLES(EC[g])) u (
      .clk(clk), .rst(rst), .instr_valid(valid[g]), .instr_ready(rdy[g]), .instr(instr),
      .alu_zero(alu_zero), .rf_raddr1(ra1[g]), .rf_raddr2(ra2[g]), .rf_waddr(wa[g]),
      .rf_we(we[g]), .imm_field(imm[g]), .alu_op(op[g]), .alu_src_imm(src[g]),
      .busy(busy[g]), .done(done[g]),
`ifdef ALU_SEQ_PERF_CNT_EN
      .zero_flag(zf[g]), .perf_retired(perf[g])
`else
      .zero_flag(zf[g])
`endif
    );
  end
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      we_cnt[i] += int'(we[i]);
      done_cnt[i] += int'(done[i]);
    end
    if (busy[0] && !bprev) acc.push_back(cyc);
    bprev = busy[0];
  end
  task automatic chk(string n, int a, int e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  task automatic issue(int k, logic [15:0] ins, int zc, output int wb);
    @(negedge clk);
    chk("ready_before_issue", int'(rdy[k]), 1);
    instr = ins;
    valid[k] = 1;
    @(negedge clk);
    valid[k] = 0;
    wb = 0;
    for (int c = 1; c < 40; c++) begin
      if (done[k]) begin
        wb = c;
        break;
      end
      alu_zero = (c == zc);
      @(negedge clk);
    end
    alu_zero = 0;
  endtask
  typedef struct {
    logic [15:0] ins;
    logic [2:0]  ra1, ra2, wa, imm, op;
    logic        src, we;
  } vec_t;
  vec_t tv[6];
  initial begin
    tv[0] = '{16'b000_011_001_000_101_1, 3'd1, 3'd0, 3'd3, 3'd5, 3'd0, 1'b1, 1'b1};
    tv[1] = '{16'b001_111_010_011_000_0, 3'd2, 3'd3, 3'd7, 3'd0, 3'd1, 1'b0, 1'b1};
    tv[2] = '{16'b111_101_100_110_010_0, 3'd4, 3'd6, 3'd5, 3'd2, 3'd7, 1'b0, 1'b0};
    tv[3] = '{16'b000_000_011_101_111_1, 3'd3, 3'd5, 3'd0, 3'd7, 3'd0, 1'b1, 1'b0};
    tv[4] = '{16'b100_001_111_111_011_1, 3'd7, 3'd7, 3'd1, 3'd3, 3'd4, 1'b1, 1'b1};
    tv[5] = '{16'b101_110_000_001_001_0, 3'd0, 3'd1, 3'd6, 3'd1, 3'd5, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", int'(rdy[i]), 1);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_we", int'(we[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_zero_flag", int'(zf[i]), 0);
    end
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      issue(0, tv[i].ins, 0, wbc);
      chk("wb_cycle", wbc, 3);
      chk("we", int'(we[0]), int'(tv[i].we));
      chk("raddr1", int'(ra1[0]), int'(tv[i].ra1));
      chk("raddr2", int'(ra2[0]), int'(tv[i].ra2));
      chk("waddr", int'(wa[0]), int'(tv[i].wa));
      chk("imm_field", int'(imm[0]), int'(tv[i].imm));
      chk("alu_op", int'(op[0]), int'(tv[i].op));
      chk("alu_src_imm", int'(src[0]), int'(tv[i].src));
      chk("busy_wb", int'(busy[0]), 1);
      chk("ready_wb", int'(rdy[0]), 0);
      @(negedge clk);
      chk("done_pulse_end", int'(done[0]), 0);
      chk("we_pulse_end", int'(we[0]), 0);
      chk("ready_after_wb", int'(rdy[0]), 1);
      chk("busy_after_wb", int'(busy[0]), 0);
    end
    chk("we_pulse_total", we_cnt[0], 4);
    chk("done_pulse_total", done_cnt[0], 6);
    issue(2, tv[0].ins, 5, wbc);
    chk("ec4_wb_cycle", wbc, 6);
    chk("ec4_zero_last", int'(zf[2]), 1);
    @(negedge clk);
    chk("ec4_zero_hold", int'(zf[2]), 1);
    chk("ec4_ready", int'(rdy[2]), 1);
    issue(2, tv[0].ins, 3, wbc);
    chk("ec4_wb_cycle2", wbc, 6);
    chk("ec4_zero_early", int'(zf[2]), 0);
    @(negedge clk);
    instr = tv[0].ins;
    valid[1] = 1;
    @(negedge clk);
    valid[1] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("midop_busy", int'(busy[1]), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midop_ready", int'(rdy[1]), 1);
    chk("midop_busy_clr", int'(busy[1]), 0);
    chk("midop_done", int'(done[1]), 0);
    chk("midop_we", int'(we[1]), 0);
    repeat (6) @(negedge clk);
    chk("midop_no_done", done_cnt[1], 0);
    chk("midop_no_we", we_cnt[1], 0);
    chk("midop_idle", int'(busy[1]), 0);
    rst = 1;
    valid[0] = 1;
    @(negedge clk);
    chk("rstvalid_ready", int'(rdy[0]), 1);
    chk("rstvalid_busy", int'(busy[0]), 0);
    rst = 0;
    valid[0] = 0;
    @(negedge clk);
    chk("rstvalid_no_xfer", int'(busy[0]), 0);
    acc.delete();
    dc0 = done_cnt[0];
`ifdef ALU_SEQ_PERF_CNT_EN
    d1 = int'(perf[0]);
`endif
    instr = tv[1].ins;
    valid[0] = 1;
    for (int c = 0; c < 40 && acc.size() < 3; c++) @(negedge clk);
    valid[0] = 0;
    repeat (8) @(negedge clk);
    chk("b2b_accepts", acc.size(), 3);
    chk("b2b_spacing1", acc.size() >= 3 ? acc[1] - acc[0] : -1, 4);
    chk("b2b_spacing2", acc.size() >= 3 ? acc[2] - acc[1] : -1, 4);
    chk("b2b_done", done_cnt[0] - dc0, 3);
`ifdef ALU_SEQ_PERF_CNT_EN
    chk("perf_retired3", int'(perf[0]) - d1, 3);
    force g_dut[0].u.perf_retired = 16'hFFFF;
    @(negedge clk);
    release g_dut[0].u.perf_retired;
    issue(0, tv[2].ins, 0, wbc);
    @(negedge clk);
    chk("perf_wrap", int'(perf[0]), 0);
`endif
    d2 = 0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
